ls_arbiter: RTL and testbench
=============================

# ls_arbiter

Single-port local-store arbiter sharing the 128-bit data memory between the pipeline memory stage (loads/stores) and the DMA engine. Sits between the memory stage, the DMA engine and the data memory. Grants at most one access per cycle and returns read data with a fixed one-cycle latency to the winning requester. Asserts a pipeline stall whenever a pipeline request is refused.

## Interface
Parameters:
- ADDR_W, 11, quadword address width (2048 x 128-bit local store)
- DATA_W, 128, data width
- STARVE_MAX, 4, consecutive refused pipeline cycles before the pipeline is forced to win; legal range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pipe_req  in  1  pipeline access request, held until granted
- pipe_we  in  1  1 = store, 0 = load
- pipe_addr  in  ADDR_W  pipeline quadword address
- pipe_wdata  in  DATA_W  pipeline store data
- pipe_gnt  out  1  pipeline access accepted this cycle
- pipe_rvalid  out  1  pipeline load data valid
- pipe_rdata  out  DATA_W  pipeline load data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request, same semantics as pipe_*
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- mem_re, mem_we  out  1  memory read / write enable; never both high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
- stall  out  1  pipe_req & ~pipe_gnt

## Operation
- Grant is combinational from the current requests and the starvation counter. Both grants are never high together.
- Default priority: DMA wins when both request.
- Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
  - increments on each cycle with pipe_req & ~pipe_gnt, saturating at STARVE_MAX;
  - clears on pipe_gnt or when pipe_req is low.
- When starve_cnt == STARVE_MAX and pipe_req is high, the pipeline wins and dma_gnt = 0.
- Granted requester drives mem_addr/mem_wdata. For a read, mem_re = 1; for a write, mem_we = 1. With no grant: mem_re = mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Return-tag register rd_owner (NONE/PIPE/DMA) loads the winner of each granted read and loads NONE on writes or idle cycles.
- Next cycle: rd_owner selects which rvalid is asserted, and mem_rdata routes to that requester's rdata. The other rdata output is driven to 0.
- Accesses are issued strictly in grant order. A store followed by a load to the same address in the next cycle returns the stored data (memory behaviour; the arbiter adds no buffering).
- Requester holds req/addr/data stable until its gnt. The arbiter does not latch request fields.

## Timing
- Reset values: pipe_rvalid = dma_rvalid = 0, both rdata = 0, starve_cnt = 0, rd_owner = NONE. Grants follow the inputs.
- Grant latency: 0 cycles (same cycle as req). Read latency: rvalid exactly 1 cycle after a granted read. Write: completes at the grant edge.
- Back-to-back grants every cycle are supported. Throughput is 1 access/cycle.
- Reset asserted mid-read: the pending rvalid is dropped and never appears after reset deasserts. starve_cnt restarts at 0.
- Reset deassertion: the first grant can occur in the first cycle with reset low.
- stall is combinational and is high in every cycle in which pipe_req = 1 and pipe_gnt = 0.

## Configuration
- LS_ARB_FAIRNESS_EN defined: the starvation counter and forced pipeline grant are compiled in, as described above.
- Not defined: no counter; strict DMA priority. The pipeline is granted only when dma_req = 0, and stall can persist indefinitely.

## Test plan
- Single pipeline load, addr 0x010 preloaded with 0xA5A5…A5: pipe_gnt same cycle; next cycle pipe_rvalid = 1, pipe_rdata = 0xA5A5…A5, dma_rvalid = 0.
- Simultaneous pipe/DMA reads to 0x001 and 0x002: DMA granted first and stall = 1; pipeline granted the following cycle; each rvalid carries its own address's data.
- DMA requests continuously while pipe_req is held (fairness on, STARVE_MAX = 4): pipe_gnt in the 5th cycle with dma_gnt = 0 that cycle; starve_cnt returns to 0. With the macro off, pipe_gnt never asserts while dma_req is high.
- Pipeline store 0x1234 to 0x020, then pipeline load 0x020 next cycle: mem_we then mem_re in consecutive cycles; load returns 0x1234.
- Reset asserted in the cycle after a granted DMA read: dma_rvalid = 0 immediately and stays 0 after release; all outputs are at reset values.
- Idle (no requests) for 10 cycles: mem_re = mem_we = 0, both rvalid = 0, stall = 0.

Source files
------------

// File: rtl/ls_arbiter.sv
// ls_arbiter: single-port local-store arbiter sharing the data memory between the pipeline and DMA.
// Define LS_ARB_FAIRNESS_EN to compile in the pipeline starvation counter; otherwise DMA has strict priority.
module ls_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_gnt,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t r_rd_owner;
    owner_t w_rd_owner_nxt;
    logic   w_force_pipe;
    logic   w_dma_gnt;
    logic   w_pipe_gnt;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("ls_arbiter: STARVE_MAX must be in 1..15");
    end

`ifdef LS_ARB_FAIRNESS_EN
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_pipe = pipe_req && (r_starve_cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (pipe_req && !w_pipe_gnt) begin
            if (r_starve_cnt != CNT_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`else
    assign w_force_pipe = 1'b0;
`endif

    // DMA wins ties unless the pipeline has been refused long enough to be forced through.
    assign w_dma_gnt  = dma_req && !w_force_pipe;
    assign w_pipe_gnt = pipe_req && !w_dma_gnt;

    assign dma_gnt  = w_dma_gnt;
    assign pipe_gnt = w_pipe_gnt;
    assign stall    = pipe_req && !w_pipe_gnt;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        w_rd_owner_nxt = OWN_NONE;
        if (w_dma_gnt) begin
            mem_re    = !dma_we;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            if (!dma_we) begin
                w_rd_owner_nxt = OWN_DMA;
            end
        end else if (w_pipe_gnt) begin
            mem_re    = !pipe_we;
            mem_we    = pipe_we;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
            if (!pipe_we) begin
                w_rd_owner_nxt = OWN_PIPE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Read data is routed only to the requester that owns the returning beat.
    assign pipe_rvalid = (r_rd_owner == OWN_PIPE);
    assign dma_rvalid  = (r_rd_owner == OWN_DMA);
    assign pipe_rdata  = (r_rd_owner == OWN_PIPE) ? mem_rdata : '0;
    assign dma_rdata   = (r_rd_owner == OWN_DMA)  ? mem_rdata : '0;

endmodule

// File: tb/tb_ls_arbiter.sv
// tb_ls_arbiter: directed self-checking bench for ls_arbiter with a behavioural 1-cycle-latency memory.
// Expectations follow LS_ARB_FAIRNESS_EN when it is defined for the build.
module tb_ls_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 128;

    localparam logic [DATA_W-1:0] D_A5 = {16{8'hA5}};
    localparam logic [DATA_W-1:0] D1   = {4{32'h0001_1111}};
    localparam logic [DATA_W-1:0] D2   = {4{32'h0002_2222}};
    localparam logic [DATA_W-1:0] D_ST = 128'h1234;

    logic              clk;
    logic              reset;
    logic              pipe_req, pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_gnt, pipe_rvalid;
    logic [DATA_W-1:0] pipe_rdata;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];

    ls_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_gnt(pipe_gnt), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: write at the edge, read data available the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr];
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    endtask

    task automatic dma_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = a; dma_wdata = d;
        #1;
        check("preload_dma_gnt", dma_gnt, 1);
        check("preload_mem_we", mem_we, 1);
        check("preload_mem_re", mem_re, 0);
        check("preload_mem_addr", mem_addr, a);
        tick();
        dma_req = 1'b0;
    endtask

    initial begin
        logic exp_pgnt, prev_p, prev_d;

        idle_inputs();
        reset = 1'b1;
        #2;
        check("rst_pipe_rvalid", pipe_rvalid, 0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_pipe_rdata", pipe_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        tick();
        reset = 1'b0;

        // Preload through DMA stores; the first grant lands in the first cycle with reset low.
        dma_store(11'h010, D_A5);
        dma_store(11'h001, D1);
        dma_store(11'h002, D2);
        #1;
        check("post_write_dma_rvalid", dma_rvalid, 0);
        check("post_write_pipe_rvalid", pipe_rvalid, 0);

        // Single pipeline load.
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 11'h010;
        #1;
        check("pload_gnt", pipe_gnt, 1);
        check("pload_stall", stall, 0);
        check("pload_mem_re", mem_re, 1);
        check("pload_mem_addr", mem_addr, 11'h010);
        tick();
        pipe_req = 1'b0;
        #1;
        check("pload_rvalid", pipe_rvalid, 1);
        check("pload_rdata", pipe_rdata, D_A5);
        check("pload_dma_rvalid", dma_rvalid, 0);
        check("pload_dma_rdata", dma_rdata, 0);
        tick();

        // Simultaneous reads: DMA first, pipeline next cycle.
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 11'h001;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 11'h002;
        #1;
        check("both_dma_gnt", dma_gnt, 1);
        check("both_pipe_gnt", pipe_gnt, 0);
        check("both_stall", stall, 1);
        check("both_mem_addr", mem_addr, 11'h002);
        tick();
        dma_req = 1'b0;
        #1;
        check("both2_pipe_gnt", pipe_gnt, 1);
        check("both2_stall", stall, 0);
        check("both2_dma_rvalid", dma_rvalid, 1);
        check("both2_dma_rdata", dma_rdata, D2);
        check("both2_pipe_rvalid", pipe_rvalid, 0);
        check("both2_pipe_rdata", pipe_rdata, 0);
        tick();
        pipe_req = 1'b0;
        #1;
        check("both3_pipe_rvalid", pipe_rvalid, 1);
        check("both3_pipe_rdata", pipe_rdata, D1);
        check("both3_dma_rvalid", dma_rvalid, 0);
        tick();

        // Continuous DMA traffic with the pipeline request held.
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 11'h010;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 11'h001;
        prev_p = 1'b0; prev_d = 1'b0;
        for (int c = 1; c <= 10; c++) begin
`ifdef LS_ARB_FAIRNESS_EN
            exp_pgnt = (c == 5) || (c == 10);
`else
            exp_pgnt = 1'b0;
`endif
            #1;
            check("starve_pipe_gnt", pipe_gnt, exp_pgnt);
            check("starve_dma_gnt", dma_gnt, !exp_pgnt);
            check("starve_stall", stall, !exp_pgnt);
            check("starve_pipe_rvalid", pipe_rvalid, prev_p);
            check("starve_dma_rvalid", dma_rvalid, prev_d);
            if (prev_p) check("starve_pipe_rdata", pipe_rdata, D_A5);
            if (prev_d) check("starve_dma_rdata", dma_rdata, D1);
            prev_p = exp_pgnt;
            prev_d = !exp_pgnt;
            tick();
        end
        dma_req = 1'b0;
        #1;
        check("starve_release_pipe_gnt", pipe_gnt, 1);
        check("starve_release_stall", stall, 0);
        tick();
        idle_inputs();
        tick();

        // Store then load to the same address in consecutive cycles.
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 11'h020; pipe_wdata = D_ST;
        #1;
        check("st_pipe_gnt", pipe_gnt, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_re", mem_re, 0);
        check("st_mem_wdata", mem_wdata, D_ST);
        tick();
        pipe_we = 1'b0; pipe_wdata = '0;
        #1;
        check("ld_mem_re", mem_re, 1);
        check("ld_mem_we", mem_we, 0);
        check("ld_mem_addr", mem_addr, 11'h020);
        check("st_no_rvalid", pipe_rvalid, 0);
        tick();
        pipe_req = 1'b0;
        #1;
        check("ld_rvalid", pipe_rvalid, 1);
        check("ld_rdata", pipe_rdata, D_ST);
        tick();

        // Reset in the cycle after a granted DMA read drops the pending rvalid.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h002;
        #1;
        check("rstmid_dma_gnt", dma_gnt, 1);
        tick();
        dma_req = 1'b0;
        reset   = 1'b1;
        #1;
        check("rstmid_dma_rvalid", dma_rvalid, 0);
        check("rstmid_dma_rdata", dma_rdata, 0);
        check("rstmid_pipe_rvalid", pipe_rvalid, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rstpost_dma_rvalid", dma_rvalid, 0);
            check("rstpost_dma_rdata", dma_rdata, 0);
            check("rstpost_pipe_rvalid", pipe_rvalid, 0);
            check("rstpost_stall", stall, 0);
            tick();
        end

        // Idle for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_mem_re", mem_re, 0);
            check("idle_mem_we", mem_we, 0);
            check("idle_pipe_rvalid", pipe_rvalid, 0);
            check("idle_dma_rvalid", dma_rvalid, 0);
            check("idle_stall", stall, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
